program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Sequences UART-based reprogramming of the instruction memory.
- Parses a framed byte stream (sync, 32-bit length, payload, checksum) from the UART receiver.
- Drives the byte-wide write port of the program memory and holds the `flash` signal. While `flash` is high, the fetch stage freezes its PC and forces it to zero.
- Sits between the UART receiver and the fetch stage. It replaces ad-hoc address counting with a checked, timed-out load protocol.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker accepted in IDLE
- MEM_BYTES, 4096, program memory capacity in bytes; maximum legal payload length
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame before abort

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- uart_data  input  8  received byte, valid when uart_received=1
- uart_received  input  1  one-cycle strobe per received byte
- flash  output  1  high while a frame is being loaded; fetch stage holds PC
- mem_we  output  1  program memory write enable, one-cycle pulse per payload byte
- mem_waddr  output  32  program memory byte address
- mem_wdata  output  8  program memory write data
- load_done  output  1  one-cycle pulse on successful frame completion
- load_err  output  1  sticky error flag
- err_code  output  2  0 none, 1 timeout, 2 length > MEM_BYTES, 3 checksum mismatch
- tx_data  output  8  ack byte to UART transmitter (feature only)
- tx_start  output  1  one-cycle transmit request (feature only)

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; length, address, checksum and timeout registers 0. Reset mid-frame aborts with no load_err.
- States: IDLE, LEN, DATA, CHECK, DONE, ERROR.
- IDLE:
  - Byte == SYNC_BYTE -> LEN. flash rises the next cycle. Clears load_err/err_code, byte index, address and checksum.
  - Other bytes are ignored.
- LEN:
  - Takes 4 bytes, little-endian, into a 32-bit length.
  - After the 4th byte: length > MEM_BYTES -> ERROR(2); length == 0 -> CHECK; else -> DATA.
- DATA:
  - Each strobe registers mem_wdata=uart_data and mem_waddr=address, and pulses mem_we the cycle after the strobe (1-cycle latency).
  - Address increments by 1 after each write.
  - Checksum = 8-bit sum of payload bytes, mod 256.
  - When the byte count reaches length -> CHECK.
- CHECK:
  - Next byte compared with the checksum. Equal -> DONE; else -> ERROR(3).
  - For length 0, the expected checksum is 8'h00.
- DONE: load_done=1 for one cycle; flash=0 from the same cycle; -> IDLE.
- ERROR: flash=0; load_err=1 and err_code held until the next accepted SYNC_BYTE; -> IDLE after one cycle.
  - Memory already written is not rolled back.
- Timeout:
  - Counter runs in LEN/DATA/CHECK, cleared on every uart_received.
  - Reaching TIMEOUT_CYCLES -> ERROR(1).
  - A strobe in the same cycle as expiry wins: the byte is accepted and the counter is cleared.
- mem_waddr never exceeds MEM_BYTES-1; guaranteed by the length check.
- A SYNC_BYTE value received inside a frame is treated as data, not resync.
- flash is registered and glitch-free: high exactly from the cycle after sync acceptance through the cycle before DONE or ERROR.

Optional Feature:
- Macro: PROGRAM_LOADER_ACK_EN.
- Defined: on entering DONE, tx_data=8'h06 and tx_start pulses 1 cycle. On entering ERROR, tx_data=8'h15 and tx_start pulses.
- Not defined: tx_data=0 and tx_start=0 constantly; no other behaviour changes.

Test Plan:
- Reset during DATA after 3 of 8 bytes -> flash=0, mem_we=0, load_err=0. A fresh frame then loads from address 0.
- Frame A5, 04 00 00 00, 13 00 00 00, checksum 13 -> mem_we pulses at addresses 0..3 with data 13,00,00,00; load_done pulses; flash falls; load_err=0.
- Frame A5, 01 10 00 00 (length 0x1001 > 4096) -> ERROR, err_code=2, no mem_we, flash=0.
- Frame A5, 02 00 00 00, 01 02, checksum 04 -> bytes written to addresses 0,1; err_code=3, load_err=1. A new A5 then clears load_err.
- Frame A5, 02 00 00 00, 01, then silence for TIMEOUT_CYCLES (bench sets 100) -> err_code=1 at cycle 100 after the last strobe. A strobe landing exactly at cycle 100 instead keeps the frame alive.
- With PROGRAM_LOADER_ACK_EN: good frame -> tx_start with 8'h06 in the DONE cycle. Bad checksum -> tx_start with 8'h15. Without the macro, tx_start stays 0.

Source files
------------

// File: rtl/program_loader.sv
// UART frame loader: sync, 32-bit little-endian length, payload, 8-bit additive checksum.
// Define PROGRAM_LOADER_ACK_EN to emit an ACK (8'h06) / NAK (8'h15) byte at the end of each frame.
module program_loader #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned MEM_BYTES      = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  uart_data,
   input  logic        uart_received,
   output logic        flash,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [7:0]  mem_wdata,
   output logic        load_done,
   output logic        load_err,
   output logic [1:0]  err_code,
   output logic [7:0]  tx_data,
   output logic        tx_start
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   localparam logic [31:0] LP_MEM_BYTES = 32'(MEM_BYTES);
   localparam logic [31:0] LP_TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_len, w_len_nxt;
   logic [1:0]  r_lidx, w_lidx_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [7:0]  r_sum, w_sum_nxt;
   logic [31:0] r_tmo, w_tmo_nxt;
   logic        r_flash, w_flash_nxt;
   logic        r_mem_we, w_mem_we_nxt;
   logic [31:0] r_mem_waddr, w_mem_waddr_nxt;
   logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
   logic        r_load_done, w_load_done_nxt;
   logic        r_load_err, w_load_err_nxt;
   logic [1:0]  r_err_code, w_err_code_nxt;
   logic [7:0]  r_tx_data, w_tx_data_nxt;
   logic        r_tx_start, w_tx_start_nxt;

   logic        w_fail, w_pass;
   logic [1:0]  w_fail_code;
   logic [31:0] w_len_shift;
   logic [31:0] w_addr_inc;
   logic        w_in_frame;
   logic        w_tmo_hit;

   // Length bytes arrive LSB first, so each new byte enters at the top and shifts down.
   assign w_len_shift = {uart_data, r_len[31:8]};
   assign w_addr_inc  = r_addr + 32'd1;
   assign w_in_frame  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHECK);
   assign w_tmo_hit   = (r_tmo == LP_TMO_LAST) && !uart_received;

   // Next-state and next-output logic for every register.
   always_comb begin
      w_state_nxt     = r_state;
      w_len_nxt       = r_len;
      w_lidx_nxt      = r_lidx;
      w_addr_nxt      = r_addr;
      w_sum_nxt       = r_sum;
      w_flash_nxt     = r_flash;
      w_mem_we_nxt    = 1'b0;
      w_mem_waddr_nxt = r_mem_waddr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_load_done_nxt = 1'b0;
      w_load_err_nxt  = r_load_err;
      w_err_code_nxt  = r_err_code;
      w_tx_data_nxt   = r_tx_data;
      w_tx_start_nxt  = 1'b0;
      w_fail          = 1'b0;
      w_fail_code     = 2'd0;
      w_pass          = 1'b0;

      if (w_in_frame && !uart_received) begin
         w_tmo_nxt = r_tmo + 32'd1;
      end else begin
         w_tmo_nxt = 32'd0;
      end

      case (r_state)
         S_IDLE: begin
            if (uart_received && (uart_data == SYNC_BYTE)) begin
               w_state_nxt    = S_LEN;
               w_flash_nxt    = 1'b1;
               w_load_err_nxt = 1'b0;
               w_err_code_nxt = 2'd0;
               w_len_nxt      = 32'd0;
               w_lidx_nxt     = 2'd0;
               w_addr_nxt     = 32'd0;
               w_sum_nxt      = 8'd0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LEN: begin
            if (uart_received) begin
               w_len_nxt  = w_len_shift;
               w_lidx_nxt = r_lidx + 2'd1;
               if (r_lidx != 2'd3) begin
                  w_state_nxt = S_LEN;
               end else if (w_len_shift > LP_MEM_BYTES) begin
                  w_fail      = 1'b1;
                  w_fail_code = 2'd2;
               end else if (w_len_shift == 32'd0) begin
                  w_state_nxt = S_CHECK;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end else begin
               w_fail      = w_tmo_hit;
               w_fail_code = 2'd1;
            end
         end
         S_DATA: begin
            if (uart_received) begin
               w_mem_we_nxt    = 1'b1;
               w_mem_waddr_nxt = r_addr;
               w_mem_wdata_nxt = uart_data;
               w_addr_nxt      = w_addr_inc;
               w_sum_nxt       = r_sum + uart_data;
               if (w_addr_inc == r_len) begin
                  w_state_nxt = S_CHECK;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end else begin
               w_fail      = w_tmo_hit;
               w_fail_code = 2'd1;
            end
         end
         S_CHECK: begin
            if (uart_received) begin
               w_pass      = (uart_data == r_sum);
               w_fail      = (uart_data != r_sum);
               w_fail_code = 2'd3;
            end else begin
               w_fail      = w_tmo_hit;
               w_fail_code = 2'd1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERROR: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_fail) begin
         w_state_nxt    = S_ERROR;
         w_flash_nxt    = 1'b0;
         w_load_err_nxt = 1'b1;
         w_err_code_nxt = w_fail_code;
      end else if (w_pass) begin
         w_state_nxt     = S_DONE;
         w_flash_nxt     = 1'b0;
         w_load_done_nxt = 1'b1;
      end else begin
         w_load_done_nxt = 1'b0;
      end

`ifdef PROGRAM_LOADER_ACK_EN
      if (w_pass) begin
         w_tx_data_nxt  = 8'h06;
         w_tx_start_nxt = 1'b1;
      end else if (w_fail) begin
         w_tx_data_nxt  = 8'h15;
         w_tx_start_nxt = 1'b1;
      end else begin
         w_tx_start_nxt = 1'b0;
      end
`else
      w_tx_data_nxt  = 8'h00;
      w_tx_start_nxt = 1'b0;
`endif
   end

   // State and output registers; reset abandons any frame without flagging an error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_len       <= 32'd0;
         r_lidx      <= 2'd0;
         r_addr      <= 32'd0;
         r_sum       <= 8'd0;
         r_tmo       <= 32'd0;
         r_flash     <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_waddr <= 32'd0;
         r_mem_wdata <= 8'd0;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
         r_err_code  <= 2'd0;
         r_tx_data   <= 8'd0;
         r_tx_start  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_lidx      <= w_lidx_nxt;
         r_addr      <= w_addr_nxt;
         r_sum       <= w_sum_nxt;
         r_tmo       <= w_tmo_nxt;
         r_flash     <= w_flash_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_waddr <= w_mem_waddr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_load_done <= w_load_done_nxt;
         r_load_err  <= w_load_err_nxt;
         r_err_code  <= w_err_code_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_tx_start  <= w_tx_start_nxt;
      end
   end

   assign flash     = r_flash;
   assign mem_we    = r_mem_we;
   assign mem_waddr = r_mem_waddr;
   assign mem_wdata = r_mem_wdata;
   assign load_done = r_load_done;
   assign load_err  = r_load_err;
   assign err_code  = r_err_code;
   assign tx_data   = r_tx_data;
   assign tx_start  = r_tx_start;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (timeout shortened to 100 cycles).
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  uart_data;
   logic        uart_received;
   logic        flash, mem_we, load_done, load_err, tx_start;
   logic [31:0] mem_waddr;
   logic [7:0]  mem_wdata, tx_data;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;

`ifdef PROGRAM_LOADER_ACK_EN
   localparam logic ACK_ON = 1'b1;
`else
   localparam logic ACK_ON = 1'b0;
`endif

   program_loader #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .uart_data(uart_data), .uart_received(uart_received),
      .flash(flash), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .load_done(load_done), .load_err(load_err), .err_code(err_code),
      .tx_data(tx_data), .tx_start(tx_start)
   );

   always #5 clk = ~clk;

   // One strobe; returns 1 time unit after the edge that sampled it.
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      uart_data = b; uart_received = 1'b1;
      @(posedge clk); #1;
      uart_received = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] len);
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_reset();
      uart_data = 8'h00; uart_received = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++; if ({flash, mem_we, load_done, load_err, tx_start} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {flash, mem_we, load_done, load_err, tx_start}); end
      checks++; if ({mem_waddr, mem_wdata, tx_data, err_code} !== 50'd0) begin errors++; $display("FAIL reset_buses got %h exp 0", {mem_waddr, mem_wdata, tx_data, err_code}); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      send_hdr(32'd8);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      checks++; if (flash !== 1'b1) begin errors++; $display("FAIL midframe_flash got %b exp 1", flash); end
      #1 rst = 1'b1; #2;
      checks++; if ({flash, mem_we, load_err} !== 3'b000) begin errors++; $display("FAIL midframe_reset got %b exp 000", {flash, mem_we, load_err}); end
      @(posedge clk); #1 rst = 1'b0;
      send_hdr(32'd1);
      send_byte(8'h7E);
      checks++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'd0, 8'h7E}) begin errors++; $display("FAIL fresh_write got %b/%h/%h exp 1/0/7e", mem_we, mem_waddr, mem_wdata); end
      send_byte(8'h7E);
      checks++; if ({load_done, flash, load_err} !== 3'b100) begin errors++; $display("FAIL fresh_done got %b exp 100", {load_done, flash, load_err}); end
   endtask

   task automatic test_good_frame();
      logic [7:0] pay [4] = '{8'h13, 8'h00, 8'h00, 8'h00};
      send_byte(8'hA5);
      checks++; if (flash !== 1'b1) begin errors++; $display("FAIL good_flash_rise got %b exp 1", flash); end
      send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      for (int i = 0; i < 4; i++) begin
         send_byte(pay[i]);
         checks++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'(i), pay[i]}) begin errors++; $display("FAIL good_write%0d got %b/%h/%h exp 1/%h/%h", i, mem_we, mem_waddr, mem_wdata, i, pay[i]); end
      end
      send_byte(8'h13);
      checks++; if ({load_done, flash, load_err, err_code} !== 5'b10000) begin errors++; $display("FAIL good_done got %b exp 10000", {load_done, flash, load_err, err_code}); end
      checks++; if ({tx_start, tx_data} !== {ACK_ON, (ACK_ON ? 8'h06 : 8'h00)}) begin errors++; $display("FAIL good_ack got %b/%h exp %b", tx_start, tx_data, ACK_ON); end
      @(posedge clk); #1;
      checks++; if ({load_done, mem_we, tx_start} !== 3'b000) begin errors++; $display("FAIL good_pulse_end got %b exp 000", {load_done, mem_we, tx_start}); end
   endtask

   task automatic test_zero_len();
      send_hdr(32'd0);
      send_byte(8'h00);
      checks++; if ({load_done, flash, load_err} !== 3'b100) begin errors++; $display("FAIL zero_len_done got %b exp 100", {load_done, flash, load_err}); end
   endtask

   task automatic test_len_err();
      send_hdr(32'h0000_1000);
      checks++; if ({flash, load_err} !== 2'b10) begin errors++; $display("FAIL len_max_ok got %b exp 10", {flash, load_err}); end
      pulse_reset();
      send_hdr(32'h0000_1001);
      checks++; if ({load_err, err_code, flash, mem_we} !== 5'b11000) begin errors++; $display("FAIL len_err got %b exp 11000", {load_err, err_code, flash, mem_we}); end
      @(posedge clk); #1;
      checks++; if ({load_err, err_code} !== 3'b110) begin errors++; $display("FAIL len_err_sticky got %b exp 110", {load_err, err_code}); end
   endtask

   task automatic test_checksum_err();
      send_hdr(32'd2);
      send_byte(8'h01);
      checks++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'd0, 8'h01}) begin errors++; $display("FAIL cks_write0 got %b/%h/%h exp 1/0/01", mem_we, mem_waddr, mem_wdata); end
      send_byte(8'h02);
      checks++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'd1, 8'h02}) begin errors++; $display("FAIL cks_write1 got %b/%h/%h exp 1/1/02", mem_we, mem_waddr, mem_wdata); end
      send_byte(8'h04);
      checks++; if ({load_err, err_code, flash, load_done} !== 5'b11100) begin errors++; $display("FAIL cks_err got %b exp 11100", {load_err, err_code, flash, load_done}); end
      checks++; if ({tx_start, tx_data} !== {ACK_ON, (ACK_ON ? 8'h15 : 8'h00)}) begin errors++; $display("FAIL cks_nak got %b/%h exp %b", tx_start, tx_data, ACK_ON); end
      send_byte(8'h5A);
      checks++; if ({load_err, err_code, flash} !== 4'b1110) begin errors++; $display("FAIL cks_nonsync_ignored got %b exp 1110", {load_err, err_code, flash}); end
      send_byte(8'hA5);
      checks++; if ({load_err, err_code, flash} !== 4'b0001) begin errors++; $display("FAIL cks_clear got %b exp 0001", {load_err, err_code, flash}); end
      pulse_reset();
   endtask

   task automatic test_timeout();
      send_hdr(32'd2);
      send_byte(8'h01);
      repeat (99) @(posedge clk); #1;
      checks++; if ({err_code, flash} !== 3'b001) begin errors++; $display("FAIL tmo_early got %b exp 001", {err_code, flash}); end
      @(posedge clk); #1;
      checks++; if ({load_err, err_code, flash} !== 4'b1010) begin errors++; $display("FAIL tmo_fire got %b exp 1010", {load_err, err_code, flash}); end
   endtask

   task automatic test_timeout_boundary();
      send_hdr(32'd2);
      send_byte(8'h01);
      repeat (98) @(posedge clk);
      send_byte(8'h02);
      checks++; if ({err_code, flash, mem_we, mem_waddr} !== {2'd0, 1'b1, 1'b1, 32'd1}) begin errors++; $display("FAIL tmo_edge_strobe got %b/%b/%b/%h exp 0/1/1/1", err_code, flash, mem_we, mem_waddr); end
      send_byte(8'hA5);
      checks++; if ({load_err, err_code, flash} !== 4'b1110) begin errors++; $display("FAIL tmo_edge_sync_as_cks got %b exp 1110", {load_err, err_code, flash}); end
   endtask

   task automatic test_back_to_back();
      send_hdr(32'd3);
      send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h5C);
      checks++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 32'd2, 8'h5C}) begin errors++; $display("FAIL b2b_write got %b/%h/%h exp 1/2/5c", mem_we, mem_waddr, mem_wdata); end
      send_byte(8'h00);
      checks++; if ({load_done, flash, load_err} !== 3'b100) begin errors++; $display("FAIL b2b_done got %b exp 100", {load_done, flash, load_err}); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_frame();
      test_good_frame();
      test_zero_len();
      test_len_err();
      test_checksum_err();
      test_timeout();
      test_timeout_boundary();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
